// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: state codes, datapath
// select encodings and the per-state Moore control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } ctrl_t;

    // Moore control word for a state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
            end
            S_DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            S_EXECUTER: begin
                c.alusrcb = SRCB_REG;
                c.aluop   = 1'b1;
            end
            S_EXECUTEI: begin
                c.alusrcb = SRCB_EXT;
                c.aluop   = 1'b1;
            end
            S_ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regw      = 1'b1;
            end
            S_MEMADR: begin
                c.alusrcb = SRCB_EXT;
            end
            S_MEMRD: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
            end
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regw      = 1'b1;
            end
            S_MEMWR: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
                c.memw      = 1'b1;
            end
            S_BRANCH: begin
                c.alusrcb   = SRCB_EXT;
                c.resultsrc = RES_ALURESULT;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode: maps ALUOp and the instruction cmd/S bits onto the
// ALU function select, flag-write enables and the compare-only NoWrite.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       aluop,
    input  logic [5:0] funct,
    output logic [1:0] alucontrol,
    output logic [1:0] flagw,
    output logic       nowrite
);

    always_comb begin
        alucontrol = ALU_ADD;
        flagw      = 2'b00;
        nowrite    = 1'b0;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: alucontrol = ALU_ADD;
                4'b0010: alucontrol = ALU_SUB;
                4'b0000: alucontrol = ALU_AND;
                4'b1100: alucontrol = ALU_ORR;
                4'b1010: begin
                    alucontrol = ALU_SUB;
                    nowrite    = 1'b1;
                end
                default: alucontrol = ALU_ADD;
            endcase
            // Logic ops leave C/V alone; only arithmetic updates them.
            flagw[1] = funct[0];
            flagw[0] = funct[0] & ((alucontrol == ALU_ADD) | (alucontrol == ALU_SUB));
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: registered Moore control word per state, with
// ALU decode and PCS derived combinationally; enables are masked during reset.
module main_control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic [3:0] State
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [1:0] dec_flagw;

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_DP:    state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:   state_nxt = S_MEMADR;
                    OP_BR:    state_nxt = S_BRANCH;
                    OP_UNDEF: state_nxt = S_FETCH;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_MEMADR:   state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWR:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state so it always matches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt);
        end
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl_q.aluop),
        .funct      (Funct),
        .alucontrol (ALUControl),
        .flagw      (dec_flagw),
        .nowrite    (NoWrite)
    );

    // State already reads FETCH during reset; architectural enables stay quiet.
    assign IRWrite   = ctrl_q.irwrite & ~reset;
    assign NextPC    = ctrl_q.nextpc  & ~reset;
    assign RegW      = ctrl_q.regw    & ~reset;
    assign MemW      = ctrl_q.memw    & ~reset;
    assign FlagW     = dec_flagw & {2{~reset}};
    assign PCS       = ((ctrl_q.regw & (Rd == 4'b1111)) | ctrl_q.branch) & ~reset;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;
    assign ResultSrc = ctrl_q.resultsrc;
    assign State     = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: walks each instruction class through
// its states and checks controls against hand-derived values.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl;
    logic       RegW, MemW, PCS, NoWrite;
    logic [1:0] FlagW;
    logic [3:0] State;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCS        (PCS),
        .NoWrite    (NoWrite),
        .FlagW      (FlagW),
        .State      (State)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] st;
        logic [1:0] alc;
        logic [1:0] flw;
        logic       nw;
        logic [1:0] srcb;
        logic       pcs;
    } dp_vec_t;

    dp_vec_t dp_tbl [6];

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dp_tbl[0] = '{6'b001001, 4'd1,  4'd6, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0}; // ADDS reg
        dp_tbl[1] = '{6'b110101, 4'd1,  4'd7, 2'b01, 2'b11, 1'b1, 2'b01, 1'b0}; // CMP imm
        dp_tbl[2] = '{6'b000001, 4'd2,  4'd6, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0}; // ANDS
        dp_tbl[3] = '{6'b011000, 4'd15, 4'd6, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1}; // ORR to PC
        dp_tbl[4] = '{6'b000100, 4'd3,  4'd6, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0}; // SUB
        dp_tbl[5] = '{6'b111111, 4'd4,  4'd7, 2'b00, 2'b11, 1'b0, 2'b01, 1'b0}; // other cmd

        reset = 1'b1; Op = 2'b00; Funct = 6'b001001; Rd = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state",   8'(State),   8'd0);
        check("rst_irwrite", 8'(IRWrite), 8'd0);
        check("rst_nextpc",  8'(NextPC),  8'd0);
        check("rst_regw",    8'(RegW),    8'd0);
        check("rst_memw",    8'(MemW),    8'd0);
        check("rst_pcs",     8'(PCS),     8'd0);
        check("rst_flagw",   8'(FlagW),   8'd0);

        reset = 1'b0;
        #1;
        check("fetch_irwrite", 8'(IRWrite), 8'd1);
        check("fetch_nextpc",  8'(NextPC),  8'd1);
        check("fetch_srcb",    8'(ALUSrcB), 8'd2);
        check("fetch_srca",    8'(ALUSrcA), 8'd1);
        check("fetch_res",     8'(ResultSrc), 8'd2);

        // Data-processing: FETCH, DECODE, EXECUTE, ALUWB, back to FETCH.
        for (int i = 0; i < 6; i++) begin
            check("dp_fetch", 8'(State), 8'd0);
            Funct = dp_tbl[i].funct; Rd = dp_tbl[i].rd; Op = 2'b00;
            @(negedge clk);
            check("dp_decode", 8'(State), 8'd1);
            check("dp_decode_irw", 8'(IRWrite), 8'd0);
            @(negedge clk);
            check("dp_exec_state", 8'(State),      8'(dp_tbl[i].st));
            check("dp_exec_alc",   8'(ALUControl), 8'(dp_tbl[i].alc));
            check("dp_exec_flagw", 8'(FlagW),      8'(dp_tbl[i].flw));
            check("dp_exec_nowr",  8'(NoWrite),    8'(dp_tbl[i].nw));
            check("dp_exec_srcb",  8'(ALUSrcB),    8'(dp_tbl[i].srcb));
            check("dp_exec_srca",  8'(ALUSrcA),    8'd0);
            check("dp_exec_regw",  8'(RegW),       8'd0);
            @(negedge clk);
            check("dp_wb_state", 8'(State),     8'd8);
            check("dp_wb_regw",  8'(RegW),      8'd1);
            check("dp_wb_pcs",   8'(PCS),       8'(dp_tbl[i].pcs));
            check("dp_wb_res",   8'(ResultSrc), 8'd0);
            check("dp_wb_flagw", 8'(FlagW),     8'd0);
            @(negedge clk);
        end

        // LDR to PC: five cycles.
        check("ldr_fetch", 8'(State), 8'd0);
        Op = 2'b01; Funct = 6'b000001; Rd = 4'd15;
        @(negedge clk);
        check("ldr_decode", 8'(State), 8'd1);
        @(negedge clk);
        check("ldr_adr_state", 8'(State),      8'd2);
        check("ldr_adr_srcb",  8'(ALUSrcB),    8'd1);
        check("ldr_adr_alc",   8'(ALUControl), 8'd0);
        check("ldr_adr_flagw", 8'(FlagW),      8'd0);
        @(negedge clk);
        check("ldr_rd_state",  8'(State),  8'd3);
        check("ldr_rd_adrsrc", 8'(AdrSrc), 8'd1);
        check("ldr_rd_memw",   8'(MemW),   8'd0);
        @(negedge clk);
        check("ldr_wb_state", 8'(State),     8'd4);
        check("ldr_wb_res",   8'(ResultSrc), 8'd1);
        check("ldr_wb_regw",  8'(RegW),      8'd1);
        check("ldr_wb_pcs",   8'(PCS),       8'd1);
        @(negedge clk);
        check("ldr_done", 8'(State), 8'd0);

        // STR: four cycles.
        Op = 2'b01; Funct = 6'b000000; Rd = 4'd15;
        @(negedge clk);
        @(negedge clk);
        check("str_adr_state", 8'(State), 8'd2);
        @(negedge clk);
        check("str_wr_state",  8'(State),  8'd5);
        check("str_wr_memw",   8'(MemW),   8'd1);
        check("str_wr_adrsrc", 8'(AdrSrc), 8'd1);
        check("str_wr_regw",   8'(RegW),   8'd0);
        check("str_wr_pcs",    8'(PCS),    8'd0);
        @(negedge clk);
        check("str_done", 8'(State), 8'd0);

        // Branch: three cycles.
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("br_state", 8'(State),     8'd9);
        check("br_pcs",   8'(PCS),       8'd1);
        check("br_srcb",  8'(ALUSrcB),   8'd1);
        check("br_res",   8'(ResultSrc), 8'd2);
        check("br_regw",  8'(RegW),      8'd0);
        @(negedge clk);
        check("br_done", 8'(State), 8'd0);

        // Undefined opcode: two cycles.
        Op = 2'b11;
        @(negedge clk);
        check("undef_decode", 8'(State), 8'd1);
        @(negedge clk);
        check("undef_done", 8'(State), 8'd0);

        // Reset in the middle of a load.
        Op = 2'b01; Funct = 6'b000001; Rd = 4'd15;
        repeat (3) @(negedge clk);
        check("mid_memrd", 8'(State), 8'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_memw", 8'(MemW),    8'd0);
        check("mid_rst_regw", 8'(RegW),    8'd0);
        check("mid_rst_irw",  8'(IRWrite), 8'd0);
        @(negedge clk);
        check("mid_rst_state", 8'(State), 8'd0);
        check("mid_rst_regw2", 8'(RegW),  8'd0);
        check("mid_rst_pcs",   8'(PCS),   8'd0);
        reset = 1'b0;
        #1;
        check("post_rst_irw", 8'(IRWrite), 8'd1);
        @(negedge clk);
        check("post_rst_decode", 8'(State), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
